// File: rtl/music_fetch.sv
// music_fetch: instruction fetch and repeat-resolution stage for the note player.
// Reads 16-bit music words from an asynchronous SRAM, resolves REP1/REP2 pairs with a
// nested loop stack and hands a flat stream of note/BPM/END words over valid/ready.
//
// Optional feature macro: MUSIC_FETCH_REP_EN
//   defined   -> repeat resolution with a RepDepth-entry loop stack
//   undefined -> REP1/REP2 words are skipped, loop_depth_o tied to 0
//
// Ports:
//   clk_i          system clock
//   rst_ni         synchronous active-low reset
//   sram_a_o       SRAM word address (program counter)
//   sram_d_i       SRAM read data
//   sram_*_o       SRAM strobes, constant read-enable
//   ins_valid_o    ins_data_o holds a word for the player
//   ins_ready_i    player accepts the word this cycle
//   ins_data_o     note, BPM or END word
//   done_o         END accepted, fetch halted
//   err_o          sticky error flag
//   loop_depth_o   occupied loop-stack entries
module music_fetch #(
  parameter int unsigned AddrW    = 18,
  parameter int unsigned RepDepth = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [AddrW-1:0] sram_a_o,
  input  logic [15:0]      sram_d_i,
  output logic             sram_we_o,
  output logic             sram_ce_o,
  output logic             sram_oe_o,
  output logic             sram_lb_o,
  output logic             sram_ub_o,
  output logic             ins_valid_o,
  input  logic             ins_ready_i,
  output logic [15:0]      ins_data_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       loop_depth_o
);

  // loop_depth_o is 3 bits wide, so deeper stacks cannot be reported.
  if (RepDepth > 7) begin : g_bad_depth
    $error("RepDepth must not exceed 7");
  end

  typedef enum logic [2:0] {StFetch, StWait, StLatch, StDecode, StOut, StHalt} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic [AddrW-1:0] pc_inc;
  logic [15:0]      ir_q, ir_d;
  logic [15:0]      data_q, data_d;
  logic             err_q, err_d;

  assign pc_inc = pc_q + AddrW'(1);

`ifdef MUSIC_FETCH_REP_EN
  logic             pend_q, pend_d;
  logic [11:0]      rep_hi_q, rep_hi_d;
  logic [AddrW-1:0] rep_p_q, rep_p_d;
  logic [2:0]       depth_q, depth_d;
  logic [AddrW-1:0] stk_line_q [RepDepth];
  logic [AddrW-1:0] stk_line_d [RepDepth];
  logic [5:0]       stk_rem_q  [RepDepth];
  logic [5:0]       stk_rem_d  [RepDepth];
  logic [2:0]       top_idx;
  logic [AddrW-1:0] rep_tgt, rep_next;
  logic             top_hit;

  assign top_idx  = depth_q - 3'd1;
  assign rep_tgt  = AddrW'({rep_hi_q, ir_q[11:6]});
  assign rep_next = rep_p_q + AddrW'(2);
  // A REP2 that revisits the pair on top of the stack is a loop back-edge, not a new loop.
  assign top_hit  = (depth_q != 3'd0) && (stk_line_q[top_idx] == rep_p_q);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef MUSIC_FETCH_REP_EN
    pend_d     = pend_q;
    rep_hi_d   = rep_hi_q;
    rep_p_d    = rep_p_q;
    depth_d    = depth_q;
    stk_line_d = stk_line_q;
    stk_rem_d  = stk_rem_q;
`endif
    unique case (state_q)
      StFetch:  state_d = StWait;
      StWait:   state_d = StLatch;
      StLatch: begin
        ir_d    = sram_d_i;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StFetch;
`ifdef MUSIC_FETCH_REP_EN
        // Orphaned REP1: flag it, drop it, then decode the current word normally.
        if (pend_q && (ir_q[15:12] != 4'b0011)) begin
          err_d  = 1'b1;
          pend_d = 1'b0;
        end
`endif
        casez (ir_q[15:12])
          4'b1???, 4'b000?: begin
            data_d  = ir_q;
            state_d = StOut;
          end
          4'b0010: begin
            pc_d = pc_inc;
`ifdef MUSIC_FETCH_REP_EN
            rep_hi_d = ir_q[11:0];
            rep_p_d  = pc_q;
            pend_d   = 1'b1;
`endif
          end
          4'b0011: begin
`ifdef MUSIC_FETCH_REP_EN
            if (!pend_q) begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              pend_d = 1'b0;
              if (top_hit) begin
                if (stk_rem_q[top_idx] == 6'd0) begin
                  depth_d = depth_q - 3'd1;
                  pc_d    = rep_next;
                end else begin
                  stk_rem_d[top_idx] = stk_rem_q[top_idx] - 6'd1;
                  pc_d               = rep_tgt;
                end
              end else if (ir_q[5:0] == 6'd0) begin
                pc_d = rep_next;
              end else if ((rep_tgt >= rep_p_q) || (depth_q == 3'(RepDepth))) begin
                err_d = 1'b1;
                pc_d  = rep_next;
              end else begin
                stk_line_d[depth_q] = rep_p_q;
                stk_rem_d[depth_q]  = ir_q[5:0] - 6'd1;
                depth_d             = depth_q + 3'd1;
                pc_d                = rep_tgt;
              end
            end
`else
            pc_d = pc_inc;
`endif
          end
          default: begin
            err_d = 1'b1;
            pc_d  = pc_inc;
          end
        endcase
      end
      StOut: begin
        if (ins_ready_i) begin
          pc_d    = pc_inc;
          state_d = (data_q[15:12] == 4'b0000) ? StHalt : StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MUSIC_FETCH_REP_EN
      pend_q   <= 1'b0;
      rep_hi_q <= '0;
      rep_p_q  <= '0;
      depth_q  <= '0;
      for (int i = 0; i < int'(RepDepth); i++) begin
        stk_line_q[i] <= '0;
        stk_rem_q[i]  <= '0;
      end
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MUSIC_FETCH_REP_EN
      pend_q     <= pend_d;
      rep_hi_q   <= rep_hi_d;
      rep_p_q    <= rep_p_d;
      depth_q    <= depth_d;
      stk_line_q <= stk_line_d;
      stk_rem_q  <= stk_rem_d;
`endif
    end
  end

  assign sram_a_o    = pc_q;
  assign sram_we_o   = 1'b1;
  assign sram_ce_o   = 1'b0;
  assign sram_oe_o   = 1'b0;
  assign sram_lb_o   = 1'b0;
  assign sram_ub_o   = 1'b0;
  assign ins_valid_o = (state_q == StOut);
  assign ins_data_o  = data_q;
  assign done_o      = (state_q == StHalt);
  assign err_o       = err_q;
`ifdef MUSIC_FETCH_REP_EN
  assign loop_depth_o = depth_q;
`else
  assign loop_depth_o = 3'd0;
`endif

endmodule
